// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - constants and types shared between the key sequencer and the MEM stage
package mem_pkg;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

    typedef logic [1:0] setting_t;

    // Digit 0 sits in the most-significant pair: digits 2,1,0,3.
    localparam logic [7:0] DEFAULT_KEY = 8'b10_01_00_11;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

    // Default digit for position d; longer keys repeat the 4-digit pattern.
    function automatic setting_t default_digit(input int d);
        setting_t s;
        case (d % 4)
            0:       s = DEFAULT_KEY[7:6];
            1:       s = DEFAULT_KEY[5:4];
            2:       s = DEFAULT_KEY[3:2];
            default: s = DEFAULT_KEY[1:0];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_key_index.sv
// rtl/mem_key_index.sv - modulo-NUM_DIGITS key digit index with clear and advance
module mem_key_index #(
    parameter  int NUM_DIGITS = 4,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] sel_idx_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] base;

    // A clear in the same cycle as an advance lets the advancing character use digit 0.
    always_comb begin
        base  = clear_i ? '0 : idx_q;
        idx_d = base;
        if (advance_i) begin
            idx_d = (base == LAST) ? '0 : base + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign sel_idx_o = base;

endmodule

// File: rtl/mem_key_sequencer.sv
// rtl/mem_key_sequencer.sv - tags each character with its key-digit setting for the MEM stage
module mem_key_sequencer
    import mem_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_load,
    input  logic [2*NUM_DIGITS-1:0] key,
    input  logic                    msg_start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_char,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_char,
    output setting_t                out_setting,
    output logic                    out_bypass,
    output logic [CNT_W-1:0]        letter_count
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [2*NUM_DIGITS-1:0] build_default_key();
        logic [2*NUM_DIGITS-1:0] k;
        k = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            k[2*(NUM_DIGITS-1-d) +: 2] = default_digit(d);
        end
        return k;
    endfunction

    localparam logic [2*NUM_DIGITS-1:0] KEY_RST = build_default_key();

    logic [2*NUM_DIGITS-1:0] key_q, key_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic [7:0]              char_q, char_d;
    setting_t                setting_q, setting_d;
    logic                    bypass_q, bypass_d;

    logic             xfer;
    logic             letter;
    logic             restart;
    logic [IDX_W-1:0] sel_idx;
    setting_t         sel_setting;

    // key_load owns the cycle, so a transfer can never coincide with a key change.
    assign in_ready = !rst && !key_load && (!valid_q || out_ready);
    assign xfer     = in_valid && in_ready;
    assign letter   = is_letter(in_char);
    assign restart  = key_load || msg_start;

    mem_key_index #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_index (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (restart),
        .advance_i (xfer && letter),
        .sel_idx_o (sel_idx)
    );

    always_comb begin
        sel_setting = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (IDX_W'(d) == sel_idx) begin
                sel_setting = key_q[2*(NUM_DIGITS-1-d) +: 2];
            end
        end
    end

    always_comb begin
        key_d = key_load ? key : key_q;

        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = (xfer && letter) ? CNT_W'(1) : '0;
        end else if (xfer && letter && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        valid_d   = valid_q;
        char_d    = char_q;
        setting_d = setting_q;
        bypass_d  = bypass_q;
        if (xfer) begin
            valid_d   = 1'b1;
            char_d    = in_char;
            setting_d = sel_setting;
            bypass_d  = !letter;
        end else if (out_ready) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q     <= KEY_RST;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            char_q    <= 8'h00;
            setting_q <= '0;
            bypass_q  <= 1'b0;
        end else begin
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            char_q    <= char_d;
            setting_q <= setting_d;
            bypass_q  <= bypass_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_char     = char_q;
    assign out_setting  = setting_q;
    assign out_bypass   = bypass_q;
    assign letter_count = cnt_q;

endmodule

// File: tb/tb_mem_key_sequencer.sv
// tb/tb_mem_key_sequencer.sv - directed vector bench for mem_key_sequencer
module tb_mem_key_sequencer;
    import mem_pkg::*;

    localparam int ND = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_load = 1'b0;
    logic [2*ND-1:0] key = '0;
    logic          msg_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_char = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_char;
    setting_t      out_setting;
    logic          out_bypass;
    logic [CW-1:0] letter_count;

    mem_key_sequencer #(.NUM_DIGITS(ND), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key          (key),
        .msg_start    (msg_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_char      (in_char),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_char     (out_char),
        .out_setting  (out_setting),
        .out_bypass   (out_bypass),
        .letter_count (letter_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present ch (in_valid left high for back-to-back use) and check the captured output.
    task automatic send(input string name, input logic [7:0] ch, input logic [1:0] exp_set, input int exp_cnt);
        in_valid = 1'b1;
        in_char  = ch;
        #1;
        check({name, " in_ready"}, in_ready, 1);
        tick();
        check({name, " out_valid"}, out_valid, 1);
        check({name, " out_char"}, out_char, ch);
        check({name, " setting"}, out_setting, exp_set);
        check({name, " count"}, letter_count, exp_cnt);
    endtask

    typedef struct {
        logic       ms;
        logic [7:0] ch;
        logic [1:0] set;
        logic       byp;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic ms, input logic [7:0] ch, input logic [1:0] set,
                                input logic byp, input int cnt);
        vec_t v;
        v.ms = ms; v.ch = ch; v.set = set; v.byp = byp; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // HELLOWORLD from reset
        add(0, "H", 2, 0, 1);  add(0, "E", 1, 0, 2);  add(0, "L", 0, 0, 3);
        add(0, "L", 3, 0, 4);  add(0, "O", 2, 0, 5);  add(0, "W", 1, 0, 6);
        add(0, "O", 0, 0, 7);  add(0, "R", 3, 0, 8);  add(0, "L", 2, 0, 9);
        add(0, "D", 1, 0, 10);
        // "HE LLO" with msg_start on the H
        add(1, "H", 2, 0, 1);  add(0, "E", 1, 0, 2);  add(0, " ", 0, 1, 2);
        add(0, "L", 0, 0, 3);  add(0, "L", 3, 0, 4);  add(0, "O", 2, 0, 5);
        // msg_start coincident with a letter, then with a non-letter
        add(1, "C", 2, 0, 1);  add(0, "D", 1, 0, 2);
        add(1, "!", 2, 1, 0);  add(0, "X", 2, 0, 1);  add(0, "Z", 1, 0, 2);
        add(0, "@", 0, 1, 2);  add(0, "[", 0, 1, 2);  add(0, "A", 0, 0, 3);
        add(0, "a", 3, 1, 3);  add(0, "M", 3, 0, 4);

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset in_ready", in_ready, 0);
        @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_char", out_char, 0);
        check("reset setting", out_setting, 0);
        check("reset bypass", out_bypass, 0);
        check("reset count", letter_count, 0);
        check("reset in_ready held", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven back-to-back stream with out_ready=1
        foreach (tbl[i]) begin
            in_valid  = 1'b1;
            in_char   = tbl[i].ch;
            msg_start = tbl[i].ms;
            #1;
            check($sformatf("vec%0d in_ready", i), in_ready, 1);
            tick();
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d out_char", i), out_char, tbl[i].ch);
            check($sformatf("vec%0d setting", i), out_setting, tbl[i].set);
            check($sformatf("vec%0d bypass", i), out_bypass, tbl[i].byp);
            check($sformatf("vec%0d count", i), letter_count, tbl[i].cnt);
        end
        in_valid  = 1'b0;
        msg_start = 1'b0;
        tick();
        check("drain out_valid", out_valid, 0);

        // msg_start alone, then backpressure for 3 cycles
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
        check("msg_start count", letter_count, 0);
        send("bp Q", "Q", 2, 1);
        out_ready = 1'b0;
        in_char   = "R";
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d in_ready", c), in_ready, 0);
            tick();
            check($sformatf("bp%0d out_valid", c), out_valid, 1);
            check($sformatf("bp%0d out_char", c), out_char, "Q");
            check($sformatf("bp%0d setting", c), out_setting, 2);
        end
        out_ready = 1'b1;
        send("bp R", "R", 1, 2);
        in_valid = 1'b0;
        tick();
        check("bp R consumed once", out_valid, 0);
        check("bp count", letter_count, 2);

        // key_load after 5 letters with the last output still pending
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
        send("kl A", "A", 2, 1);
        send("kl B", "B", 1, 2);
        send("kl C", "C", 0, 3);
        send("kl D", "D", 3, 4);
        send("kl E", "E", 2, 5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        key       = 8'b00_11_01_10;
        key_load  = 1'b1;
        msg_start = 1'b1;
        #1;
        check("kl in_ready", in_ready, 0);
        tick();
        key_load  = 1'b0;
        msg_start = 1'b0;
        check("kl held valid", out_valid, 1);
        check("kl held char", out_char, "E");
        check("kl held setting", out_setting, 2);
        check("kl count cleared", letter_count, 0);
        out_ready = 1'b1;
        send("kl F", "F", 0, 1);
        send("kl G", "G", 3, 2);
        send("kl H", "H", 1, 3);
        send("kl I", "I", 2, 4);

        // Counter saturation at all-ones
        in_valid  = 1'b0;
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
        for (int n = 0; n < 17; n++) begin
            in_valid = 1'b1;
            in_char  = 8'h41 + 8'(n % 26);
            tick();
            check($sformatf("sat%0d count", n), letter_count, (n + 1 > 15) ? 15 : n + 1);
        end

        // Reset pulse with a pending output
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        check("rst pending valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst async out_valid", out_valid, 0);
        check("rst async out_char", out_char, 0);
        check("rst async count", letter_count, 0);
        check("rst async in_ready", in_ready, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        send("post-rst P", "P", 2, 1);
        send("post-rst Q", "Q", 1, 2);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
